alu_arbiter: RTL

Shares one combinational `ALU` instance between two requesters, such as the issue stage and a debug/test port. Each transaction uses a valid/ready handshake and round-robin arbitration, registers the operands and the ALU result, and returns the result, flags and requester ID on a single back-pressured response channel. It sits between the decode/issue logic and the ALU, and is the only block that drives the ALU's `alu_select`.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/ALU.sv | 47 ++++
 rtl/rr_arb2.sv | 18 +
 rtl/alu_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, flag indices and arbiter FSM states
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SUB = 4'd0,
        OP_ADD = 4'd1,
        OP_MUL = 4'd2,
        OP_MOV = 4'd3,
        OP_CMP = 4'd4,
        OP_DIV = 4'd5,
        OP_XOR = 4'd6,
        OP_AND = 4'd7,
        OP_NOT = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10
    } alu_op_t;

    localparam logic [3:0] ALU_OP_LAST = 4'd10;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational N-bit ALU with zero/negative flags
module ALU
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alu_select,
    output logic [N-1:0] result,
    output logic [1:0]   flags
);

    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb_nz;
    logic signed [N-1:0] quot;

    // Divisor is forced non-zero so the quotient never goes undefined; callers flag b=0 themselves
    assign sa    = a;
    assign sb_nz = (b == '0) ? N'(1) : b;
    assign quot  = sa / sb_nz;

    always_comb begin
        result = '0;
        case (alu_select)
            OP_SUB:  result = a - b;
            OP_ADD:  result = a + b;
            OP_MUL:  result = a * b;
            OP_MOV:  result = a;
            OP_CMP:  result = a - b;
            OP_DIV:  result = quot;
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = a << b;
            OP_SHR:  result = a >> b;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags            = '0;
        flags[FLAG_ZERO] = (result == '0);
        flags[FLAG_NEG]  = result[N-1];
    end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters with a registered response
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][N-1:0]   req_a,
    input  logic [1:0][N-1:0]   req_b,
    input  logic [1:0][3:0]     req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N-1:0]        rsp_data,
    output logic [1:0]          rsp_flags,
    output logic                rsp_id,
    output logic                rsp_err
);

    arb_state_t  state;
    arb_state_t  state_next;
    logic        last;
    logic [1:0]  grant;
    logic        grant_id;
    logic        accept;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [3:0]  op_q;
    logic        id_q;
    logic [N-1:0] alu_result;
    logic [1:0]  alu_flags;
    logic        op_err;

    rr_arb2 u_arb (
        .valid (req_valid),
        .last  (last),
        .grant (grant)
    );

    // Ready is gated by rst_n so nothing can be accepted while reset is held
    assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
    assign grant_id  = grant[1];
    assign accept    = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP);

    ALU #(.N(N)) u_alu (
        .a          (a_q),
        .b          (b_q),
        .alu_select (op_q),
        .result     (alu_result),
        .flags      (alu_flags)
    );

    assign op_err = (op_q > ALU_OP_LAST) || (op_q == OP_DIV && b_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                a_q  <= req_a[grant_id];
                b_q  <= req_b[grant_id];
                op_q <= req_op[grant_id];
                id_q <= grant_id;
                last <= grant_id;
            end
            // Response registers load only in EXEC, so they hold through any RESP stall
            if (state == EXEC) begin
                rsp_id <= id_q;
                if (op_err) begin
                    rsp_data  <= '0;
                    rsp_flags <= 2'b01;
                    rsp_err   <= 1'b1;
                end else begin
                    rsp_data  <= alu_result;
                    rsp_flags <= alu_flags;
                    rsp_err   <= 1'b0;
                end
            end
        end
    end

endmodule
